perf_display: RTL and testbench
===============================

PERF_DISPLAY -- requirements
Module: perf_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized cycles required before a button level is accepted.
REQ-002 Parameter SCROLL_CYCLES, default 50000000: auto-scroll dwell time in cycles; used only with PERF_DISPLAY_AUTOSCROLL_EN.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 jumps  input  9  live jump counter from the pipeline core.
REQ-006 memAccess  input  9  live memory-access counter from the core.
REQ-007 cpuCycle  input  9  live cycle counter from the core.
REQ-008 intructions  input  9  live retired-instruction counter from the core.
REQ-009 btn_next  input  1  raw asynchronous push button, active-high; selects the next counter.
REQ-010 btn_freeze  input  1  raw asynchronous push button, active-high; toggles freeze.
REQ-011 hex0, hex1, hex2  output  7 each  active-low seven-segment digits, bit order gfedcba; hex0 is the least-significant nibble.
REQ-012 sel_led  output  4  one-hot selected counter: bit0 jumps, bit1 memAccess, bit2 cpuCycle, bit3 intructions.
REQ-013 frozen  output  1  high while freeze mode is active.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that changes its accepted level only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-015 A 0->1 transition of an accepted level SHALL produce a 1-cycle pulse; holding a button SHALL produce no further pulses.
REQ-016 Selection index sel (0..3) SHALL increment on each next pulse and wrap from 3 to 0; sel_led = 1 << sel.
REQ-017 Shadow bank: four 9-bit registers; when not frozen, each loads its live counter every cycle; when frozen, all four hold.
REQ-018 A freeze pulse while not frozen SHALL set frozen and capture all four counters in that same edge, giving one consistent snapshot.
REQ-019 A freeze pulse while frozen SHALL clear frozen; the shadow bank resumes live loading on the next edge.
REQ-020 Next and freeze pulses in the same cycle SHALL both take effect: sel advances and frozen toggles.
REQ-021 hex outputs SHALL be registered decodes of shadow[sel]: hex0 = bits[3:0], hex1 = bits[7:4], hex2 = {000, bit8}.
REQ-022 Latency from a counter change to the hex outputs SHALL be 2 cycles in live mode; after a sel change, hex SHALL update 1 cycle later.
REQ-023 Digit encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-024 While reset=0, all state SHALL clear immediately without waiting for clk: sel=0, frozen=0, shadow=0, debouncers and scroll timer cleared.
REQ-025 Reset output values: sel_led=0001, frozen=0, hex0/hex1/hex2=1000000.
REQ-026 A button held through reset release SHALL NOT generate a pulse; its accepted level is re-learned from 0.
REQ-027 Reset asserted mid-debounce or mid-freeze SHALL abandon that operation completely.

Configuration
REQ-028 Macro PERF_DISPLAY_AUTOSCROLL_EN, when defined:
- a timer SHALL advance sel every SCROLL_CYCLES cycles while frozen=0;
- a next pulse SHALL restart the timer;
- the timer SHALL hold while frozen=1.
REQ-029 When PERF_DISPLAY_AUTOSCROLL_EN is undefined, no scroll timer SHALL exist and sel SHALL change only on next pulses.

Verification (DEBOUNCE_CYCLES=4, SCROLL_CYCLES=16)
REQ-030 Reset, then jumps=0x1A5 held -> two cycles after reset release, hex2=1111001, hex1=0001000, hex0=0010010, sel_led=0001.
REQ-031 btn_next high for 3 cycles, then low -> sel_led stays 0001; btn_next high for 10 cycles -> sel_led=0010 after exactly one step.
REQ-032 memAccess=0x033, freeze pulse, then memAccess=0x1FF -> frozen=1 and hex shows 033; a next pulse shows the snapshot of cpuCycle, not its live value.
REQ-033 Four next pulses from sel=0 -> sel_led steps 0010, 0100, 1000, 0001 (wrap).
REQ-034 Next and freeze pressed together -> sel advances by one and frozen toggles on the same edge.
REQ-035 With the macro defined and no presses -> sel_led advances every 16 cycles; with frozen=1 it holds. With the macro undefined -> sel_led never changes without presses.

Source files
------------

// File: rtl/perf_display.sv
// Performance-counter display: debounced buttons pick one of four live
// counters for three hex digits, with freeze-to-snapshot and optional
// auto-scroll (enable by defining PERF_DISPLAY_AUTOSCROLL_EN).
// Ports: clk, reset (async, active-low), jumps/memAccess/cpuCycle/
// intructions [8:0] live counters, btn_next/btn_freeze raw buttons,
// hex0..hex2 [6:0] active-low gfedcba digits, sel_led [3:0] one-hot,
// frozen.

module perf_display_btn #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int W = $clog2(N + 1);

  logic         s1;
  logic         s2;
  logic         lvl;
  logic         armed;
  logic [1:0]   warm;
  logic [W-1:0] cnt;
  logic         done;

  assign done = (s2 != lvl) && (cnt == W'(N - 1));

  // armed only after a valid low sample, so a button held
  // through reset release is learned silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      armed <= 1'b0;
      warm  <= 2'b00;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      warm  <= {warm[0], 1'b1};
      pulse <= done && s2 && armed;
      if (warm[1] && !s2)
        armed <= 1'b1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (done) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module perf_display #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] jumps,
  input  logic [8:0] memAccess,
  input  logic [8:0] cpuCycle,
  input  logic [8:0] intructions,
  input  logic       btn_next,
  input  logic       btn_freeze,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [3:0] sel_led,
  output logic       frozen
);

  if (DEBOUNCE_CYCLES < 1 || SCROLL_CYCLES < 1) begin : g_bad_cfg
    $error("perf_display: cycle parameters must be >= 1");
  end

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic             nxt_p;
  logic             frz_p;
  logic             step;
  logic [1:0]       sel;
  logic [3:0][8:0]  shadow;
  logic [8:0]       cur;

  perf_display_btn #(.N(DEBOUNCE_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (reset),
    .raw   (btn_next),
    .pulse (nxt_p)
  );

  perf_display_btn #(.N(DEBOUNCE_CYCLES)) u_freeze (
    .clk   (clk),
    .rst_n (reset),
    .raw   (btn_freeze),
    .pulse (frz_p)
  );

`ifdef PERF_DISPLAY_AUTOSCROLL_EN
  localparam int SW = $clog2(SCROLL_CYCLES + 1);

  logic [SW-1:0] tmr;
  logic          tick;

  assign tick = !frozen && !nxt_p
             && (tmr == SW'(SCROLL_CYCLES - 1));

  // a manual step restarts the dwell; freeze parks it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr <= '0;
    end else if (nxt_p) begin
      tmr <= '0;
    end else if (!frozen) begin
      tmr <= tick ? '0 : tmr + 1'b1;
    end
  end

  assign step = nxt_p | tick;
`else
  assign step = nxt_p;
`endif

  assign cur     = shadow[sel];
  assign sel_led = 4'b0001 << sel;

  // shadow loads on the freeze edge too, so the
  // snapshot is the set sampled on that edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel    <= 2'd0;
      frozen <= 1'b0;
      shadow <= '0;
      hex0   <= 7'b1000000;
      hex1   <= 7'b1000000;
      hex2   <= 7'b1000000;
    end else begin
      if (step)
        sel <= sel + 2'd1;
      if (frz_p)
        frozen <= ~frozen;
      if (!frozen)
        shadow <= {intructions, cpuCycle, memAccess, jumps};
      hex0 <= seg(cur[3:0]);
      hex1 <= seg(cur[7:4]);
      hex2 <= seg({3'b000, cur[8]});
    end
  end

endmodule

// File: tb/tb_perf_display.sv
// Directed bench for perf_display with short debounce/scroll times.
// Drives buttons and counters, checks digits, selection and freeze.

module tb_perf_display;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] DA = 7'b0001000;
  localparam logic [6:0] DC = 7'b1000110;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] jumps;
  logic [8:0] memAccess;
  logic [8:0] cpuCycle;
  logic [8:0] intructions;
  logic       btn_next;
  logic       btn_freeze;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [3:0] sel_led;
  logic       frozen;

  int errors = 0;
  int checks = 0;

  perf_display #(
    .DEBOUNCE_CYCLES (4),
    .SCROLL_CYCLES   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .jumps       (jumps),
    .memAccess   (memAccess),
    .cpuCycle    (cpuCycle),
    .intructions (intructions),
    .btn_next    (btn_next),
    .btn_freeze  (btn_freeze),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .sel_led     (sel_led),
    .frozen      (frozen)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [8:0] got,
                     input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic press(input logic nxt, input logic frz);
    btn_next   = nxt;
    btn_freeze = frz;
    tick(10);
    btn_next   = 1'b0;
    btn_freeze = 1'b0;
    tick(10);
  endtask

  initial begin
    logic [3:0] s0;
    logic       f0;
    int         si;
    int         fi;
    int         chg;
    int         gap;

    reset       = 1'b1;
    jumps       = 9'h1A5;
    memAccess   = 9'h000;
    cpuCycle    = 9'h000;
    intructions = 9'h000;
    btn_next    = 1'b0;
    btn_freeze  = 1'b0;

    #2 reset = 1'b0;
    #1;
    chk("rst_sel_led", sel_led, 4'b0001);
    chk("rst_frozen", frozen, 1'b0);
    chk("rst_hex0", hex0, D0);
    chk("rst_hex2", hex2, D0);

    tick(3);
    reset = 1'b1;
    tick(2);
    chk("live_hex2", hex2, D1);
    chk("live_hex1", hex1, DA);
    chk("live_hex0", hex0, D5);
    chk("live_sel", sel_led, 4'b0001);

    btn_next = 1'b1;
    tick(3);
    btn_next = 1'b0;
    tick(10);
    chk("short_press", sel_led, 4'b0001);
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    tick(10);
    chk("long_press", sel_led, 4'b0010);

    memAccess = 9'h033;
    cpuCycle  = 9'h0C7;
    tick(2);
    press(1'b0, 1'b1);
    memAccess = 9'h1FF;
    cpuCycle  = 9'h155;
    tick(3);
    chk("frz_on", frozen, 1'b1);
    chk("frz_hex2", hex2, D0);
    chk("frz_hex1", hex1, D3);
    chk("frz_hex0", hex0, D3);
    press(1'b1, 1'b0);
    chk("frz_sel", sel_led, 4'b0100);
    chk("snap_hex2", hex2, D0);
    chk("snap_hex1", hex1, DC);
    chk("snap_hex0", hex0, D7);
    press(1'b0, 1'b1);
    chk("frz_off", frozen, 1'b0);
    chk("resume_hex2", hex2, D1);
    chk("resume_hex1", hex1, D5);
    chk("resume_hex0", hex0, D5);

    press(1'b1, 1'b0);
    chk("sel3", sel_led, 4'b1000);
    press(1'b1, 1'b0);
    chk("sel0", sel_led, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0);
      chk($sformatf("walk%0d", i), sel_led,
          4'b0001 << ((i + 1) % 4));
    end

    for (int k = 0; k < 2; k++) begin
      s0 = sel_led;
      f0 = frozen;
      si = -1;
      fi = -1;
      btn_next   = 1'b1;
      btn_freeze = 1'b1;
      for (int i = 0; i < 15; i++) begin
        @(posedge clk);
        #1;
        if (si < 0 && sel_led !== s0) si = i;
        if (fi < 0 && frozen !== f0) fi = i;
      end
      btn_next   = 1'b0;
      btn_freeze = 1'b0;
      tick(10);
      chk($sformatf("both_seen%0d", k),
          (si >= 0 && fi >= 0), 1'b1);
      chk($sformatf("same_edge%0d", k), si[8:0], fi[8:0]);
      chk($sformatf("both_sel%0d", k), sel_led,
          (k == 0) ? 4'b0010 : 4'b0100);
      chk($sformatf("both_frz%0d", k), frozen,
          (k == 0) ? 1'b1 : 1'b0);
    end

`ifdef PERF_DISPLAY_AUTOSCROLL_EN
    s0  = sel_led;
    gap = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (gap < 0 && sel_led !== s0) gap = i;
    end
    chk("scroll_seen", (gap >= 0), 1'b1);
    s0  = sel_led;
    gap = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (gap < 0 && sel_led !== s0) gap = i;
    end
    chk("scroll_period", gap[8:0], 9'd16);
    press(1'b0, 1'b1);
    chk("scroll_frz", frozen, 1'b1);
    s0  = sel_led;
    chg = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (sel_led !== s0) chg++;
    end
    chk("scroll_hold", chg[8:0], 9'd0);
    press(1'b0, 1'b1);
`else
    s0  = sel_led;
    chg = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (sel_led !== s0) chg++;
    end
    chk("no_scroll", chg[8:0], 9'd0);
`endif

    press(1'b0, 1'b1);
    chk("pre_rst_frz", frozen, 1'b1);
    btn_freeze = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    chk("mid_rst_frz", frozen, 1'b0);
    chk("mid_rst_sel", sel_led, 4'b0001);
    chk("mid_rst_hex1", hex1, D0);
    tick(2);
    reset = 1'b1;
    tick(20);
    chk("held_no_pulse", frozen, 1'b0);
    btn_freeze = 1'b0;
    tick(10);
    chk("held_release", frozen, 1'b0);
    press(1'b0, 1'b1);
    chk("post_rst_frz", frozen, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
